// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD converter (serial double-dabble, one bit per clock) feeding a
// 4-digit multiplexed 7-segment display driver with leading-zero blanking.
module bcd_display_ctrl #(
   parameter int N           = 10,
   parameter int REFRESH_DIV = 50000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] bin_in,
   output logic         busy,
   output logic         done,
   output logic [3:0]   bcd_U,
   output logic [3:0]   bcd_D,
   output logic [3:0]   bcd_C,
   output logic [3:0]   bcd_M,
   output logic [0:6]   seg,
   output logic [3:0]   an
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = $clog2(REFRESH_DIV);

   typedef enum logic {IDLE, CONV} state_t;

   state_t         state_reg;
   logic [15:0]    bcd_sh_reg;
   logic [N-1:0]   bin_sh_reg;
   logic [CW-1:0]  iter_reg;
   logic [15:0]    bcd_adj;
   logic [15:0]    bcd_next;
   logic           unused_adj_msb;

   logic [RW-1:0]  refresh_reg;
   logic [1:0]     scan_idx_reg;
   logic [3:0]     digit_sel;
   logic           blank;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_adjust
         assign bcd_adj[gi*4 +: 4] = (bcd_sh_reg[gi*4 +: 4] >= 4'd5)
                                     ? bcd_sh_reg[gi*4 +: 4] + 4'd3
                                     : bcd_sh_reg[gi*4 +: 4];
      end
   endgenerate

   // The thousands nibble can never overflow for N <= 13, so its carry-out is dropped.
   assign bcd_next       = {bcd_adj[14:0], bin_sh_reg[N-1]};
   assign unused_adj_msb = bcd_adj[15];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         bcd_sh_reg <= '0;
         bin_sh_reg <= '0;
         iter_reg   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bcd_U      <= 4'd0;
         bcd_D      <= 4'd0;
         bcd_C      <= 4'd0;
         bcd_M      <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  bin_sh_reg <= bin_in;
                  bcd_sh_reg <= '0;
                  iter_reg   <= '0;
                  busy       <= 1'b1;
                  state_reg  <= CONV;
               end
            end
            CONV: begin
               bcd_sh_reg <= bcd_next;
               bin_sh_reg <= bin_sh_reg << 1;
               iter_reg   <= iter_reg + 1'b1;
               if (iter_reg == CW'(N - 1)) begin
                  bcd_U     <= bcd_next[3:0];
                  bcd_D     <= bcd_next[7:4];
                  bcd_C     <= bcd_next[11:8];
                  bcd_M     <= bcd_next[15:12];
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_reg  <= '0;
         scan_idx_reg <= 2'd0;
      end else if (refresh_reg == RW'(REFRESH_DIV - 1)) begin
         refresh_reg  <= '0;
         scan_idx_reg <= scan_idx_reg + 2'd1;
      end else begin
         refresh_reg  <= refresh_reg + 1'b1;
      end
   end

   function automatic logic [0:6] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0000001;
         4'd1:    return 7'b1001111;
         4'd2:    return 7'b0010010;
         4'd3:    return 7'b0000110;
         4'd4:    return 7'b1001100;
         4'd5:    return 7'b0100100;
         4'd6:    return 7'b0100000;
         4'd7:    return 7'b0001111;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   always_comb begin
      digit_sel = bcd_U;
      blank     = 1'b0;
      case (scan_idx_reg)
         2'd0: begin
            digit_sel = bcd_U;
            blank     = 1'b0;
         end
         2'd1: begin
            digit_sel = bcd_D;
            blank     = (bcd_M == 4'd0) && (bcd_C == 4'd0) && (bcd_D == 4'd0);
         end
         2'd2: begin
            digit_sel = bcd_C;
            blank     = (bcd_M == 4'd0) && (bcd_C == 4'd0);
         end
         default: begin
            digit_sel = bcd_M;
            blank     = (bcd_M == 4'd0);
         end
      endcase
   end

   // Blanked digits keep their anode enabled; only the segments go dark.
   assign seg = blank ? 7'b1111111 : seg_decode(digit_sel);
   assign an  = ~(4'b0001 << scan_idx_reg);

endmodule
